// File: rtl/mult_share_pkg.sv
// mult_share_pkg: shared types and round-robin pick helper for the shared-multiplier controller.
package mult_share_pkg;

    typedef enum logic [1:0] {IDLE, COMPUTE, RESP} state_e;

    localparam int DEF_MUL_CYCLES = 2;
    localparam int MAX_REQ = 64;

    // Returns the first valid index searching upward from last+1 with wrap, or -1 if none.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int last, input int n);
        int idx;
        rr_pick = -1;
        for (int k = n; k >= 1; k--) begin
            idx = (last + k) % n;
            if (valid[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/Multiplier.sv
// Multiplier: combinational full-width unsigned N x N multiplier shared by the controller.
module Multiplier #(
    parameter int N = 32
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter producing a one-hot grant and its index.
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

    int pick;

    always_comb begin
        pick  = rr_pick(MAX_REQ'(req_i), int'(last_i), NUM_REQ);
        gnt_o = (pick < 0) ? '0 : NUM_REQ'(1) << pick;
        idx_o = (pick < 0) ? '0 : IDX_W'(pick);
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: time-shares one combinational multiplier among NUM_REQ requesters,
// round-robin arbitrated, with a tagged valid/ready response channel.
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int N          = 32,
    parameter int NUM_REQ    = 4,
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*N-1:0] req_a,
    input  logic [NUM_REQ*N-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*N-1:0]       rsp_p,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy
);

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N-1:0]       op_a_q, op_b_q;
    logic [2*N-1:0]     rsp_p_q, mult_out;
    logic [ID_W-1:0]    rsp_id_q, last_q, gnt_idx;
    logic               rsp_valid_q;
    logic [NUM_REQ-1:0] gnt;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(ID_W)) u_arb (
        .req_i  (req_valid),
        .last_i (last_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx)
    );

    // Only the registered operands reach the multiplier, making it a legal multicycle path.
    Multiplier #(.N(N)) u_mul (
        .a (op_a_q),
        .b (op_b_q),
        .p (mult_out)
    );

    assign req_ready = (state_q == IDLE) ? gnt : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_p     = rsp_p_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = state_q != IDLE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_p_q     <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            last_q      <= ID_W'(NUM_REQ - 1);
        end else begin
            case (state_q)
                IDLE: if (|gnt) begin
                    op_a_q   <= req_a[gnt_idx*N +: N];
                    op_b_q   <= req_b[gnt_idx*N +: N];
                    rsp_id_q <= gnt_idx;
                    last_q   <= gnt_idx;
                    cnt_q    <= CNT_W'(MUL_CYCLES - 1);
                    state_q  <= COMPUTE;
                end
                COMPUTE: if (cnt_q == '0) begin
                    rsp_p_q     <= mult_out;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl: directed scoreboard bench for the shared-multiplier controller.
module tb_mult_share_ctrl;

    localparam int N  = 8;
    localparam int NR = 4;
    localparam int MC = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [NR*N-1:0] req_a = '0;
    logic [NR*N-1:0] req_b = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [2*N-1:0]  rsp_p;
    logic [1:0]      rsp_id;
    logic            busy;

    mult_share_ctrl #(.N(N), .NUM_REQ(NR), .MUL_CYCLES(MC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] p;
    } exp_t;

    exp_t sb[$];
    int   acc_id[$];
    int   acc_cyc[$];
    int   cyc = 0, checks = 0, passed = 0, fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] a, input logic [7:0] b);
        req_valid[i]     = v;
        req_a[i*N +: N]  = a;
        req_b[i*N +: N]  = b;
    endtask

    // Observe what the coming rising edge will see, then advance to the following falling edge.
    task automatic tick();
        exp_t e;
        #1;
        if (rst_n) begin
            chk("req_ready_onehot", 32'($onehot0(req_ready)), 32'd1);
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id = 2'(i);
                    e.p  = 16'(req_a[i*N +: N]) * 16'(req_b[i*N +: N]);
                    sb.push_back(e);
                    acc_id.push_back(i);
                    acc_cyc.push_back(cyc);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_p", 32'(rsp_p), 32'(e.p));
                end
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_acc(input int n, input int budget);
        int k = 0;
        while (acc_id.size() < n && k < budget) begin tick(); k++; end
        if (acc_id.size() < n) chk("accept_timeout", 32'(acc_id.size()), 32'(n));
    endtask

    task automatic wait_rsp(input int budget);
        int k = 0;
        while (!rsp_valid && k < budget) begin tick(); k++; end
        if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((sb.size() != 0 || busy) && k < budget) begin tick(); k++; end
        if (sb.size() != 0 || busy) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
    endtask

    initial begin
        int base, c0, hs;
        logic [15:0] p0;
        logic [1:0]  id0;

        repeat (2) tick();
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp_p", 32'(rsp_p), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        tick();

        // Single request: latency and product
        set_req(0, 1'b1, 8'd12, 8'd13);
        wait_acc(1, 10);
        set_req(0, 1'b0, 8'd0, 8'd0);
        c0 = acc_cyc[0];
        chk("single_grant", 32'(acc_id[0]), 32'd0);
        chk("single_busy", 32'(busy), 32'd1);
        wait_rsp(10);
        chk("single_latency", 32'(cyc - c0), 32'(MC + 1));
        chk("single_p", 32'(rsp_p), 32'd156);
        chk("single_id", 32'(rsp_id), 32'd0);
        chk("single_busy_resp", 32'(busy), 32'd1);
        drain(10);
        chk("single_idle", 32'(busy), 32'd0);

        // All requesters valid from reset: strict rotation, fixed spacing
        reset_pulse();
        base = acc_id.size();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 8'(20 + i * 37), 8'(250 - i * 61));
        wait_acc(base + 5, 40);
        req_valid = '0;
        for (int j = 0; j < 5; j++) chk("rotation_order", 32'(acc_id[base + j]), 32'(j % NR));
        for (int j = 1; j < 5; j++)
            chk("accept_spacing", 32'(acc_cyc[base + j] - acc_cyc[base + j - 1]), 32'(MC + 2));
        drain(20);

        // Boundary operands
        set_req(3, 1'b1, 8'hFF, 8'hFF);
        wait_rsp(20);
        set_req(3, 1'b0, 8'h00, 8'h00);
        chk("allones_p", 32'(rsp_p), 32'hFE01);
        drain(10);
        set_req(1, 1'b1, 8'h00, 8'hA5);
        wait_rsp(20);
        set_req(1, 1'b0, 8'h00, 8'h00);
        chk("zero_p", 32'(rsp_p), 32'h0000);
        drain(10);

        // Backpressure
        rsp_ready = 1'b0;
        base = acc_id.size();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 8'(3 + i * 50), 8'(7 + i * 11));
        wait_rsp(20);
        p0  = rsp_p;
        id0 = rsp_id;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_p_stable", 32'(rsp_p), 32'(p0));
            chk("bp_id_stable", 32'(rsp_id), 32'(id0));
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_no_accept", 32'(acc_id.size()), 32'(base + 1));
        end
        rsp_ready = 1'b1;
        hs = cyc;
        tick();
        wait_acc(base + 2, 5);
        req_valid = '0;
        chk("bp_resume_cycle", 32'(acc_cyc[base + 1] - hs), 32'd1);
        drain(20);

        // Rotation after last=2
        reset_pulse();
        set_req(2, 1'b1, 8'd9, 8'd9);
        base = acc_id.size();
        wait_acc(base + 1, 10);
        set_req(2, 1'b0, 8'd0, 8'd0);
        drain(10);
        base = acc_id.size();
        set_req(1, 1'b1, 8'd21, 8'd4);
        set_req(3, 1'b1, 8'd33, 8'd5);
        wait_acc(base + 2, 30);
        req_valid = '0;
        chk("rot_first", 32'(acc_id[base]), 32'd3);
        chk("rot_second", 32'(acc_id[base + 1]), 32'd1);
        drain(20);

        // Reset mid-COMPUTE
        base = acc_id.size();
        set_req(2, 1'b1, 8'd200, 8'd100);
        wait_acc(base + 1, 10);
        set_req(2, 1'b0, 8'd0, 8'd0);
        chk("abort_in_compute", 32'(busy), 32'd1);
        reset_pulse();
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        base = acc_id.size();
        set_req(1, 1'b1, 8'd6, 8'd7);
        set_req(3, 1'b1, 8'd8, 8'd9);
        wait_acc(base + 1, 10);
        req_valid = '0;
        chk("abort_next_grant", 32'(acc_id[base]), 32'd1);
        drain(20);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
